// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display path: digit count, blank glyph index,
// scanner state encoding and the leading-zero helper.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] DEFAULT_BLANK_CODE = 4'd10;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpMask;
        logic        lzBlank;
    } frame_t;

    // Digit idx is a leading zero when it and every more-significant nibble are zero;
    // digit 0 always shows so a zero value still reads "0".
    function automatic logic isLeadingZero(input logic [15:0] value, input logic [1:0] idx);
        logic allZero;
        allZero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && value[k*4 +: 4] != 4'd0) begin
                allZero = 1'b0;
            end
        end
        return allZero && (idx != 2'd0);
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Bus between the control logic (master) and the display scanner (slave).
interface display_scanner_if;

    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        load;
    logic        lz_blank;
    logic [3:0]  digit_code;
    logic        dp;
    logic [3:0]  anode_n;
    logic        frame_done;
    logic        busy;

    modport master (
        output value, dp_mask, load, lz_blank,
        input  digit_code, dp, anode_n, frame_done, busy
    );

    modport slave (
        input  value, dp_mask, load, lz_blank,
        output digit_code, dp, anode_n, frame_done, busy
    );

endinterface

// File: rtl/display_scanner_scan_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero, so a load of N-1
// gives a slot of exactly N cycles.
module scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner: walks the shadow value one nibble per slot,
// separating digits with all-dark guard slots, and swaps in new values only between frames.
module display_scanner
    import display_pkg::*;
#(
    parameter int          REFRESH_DIV  = 1000,
    parameter int          GUARD_CYCLES = 2,
    parameter logic [3:0]  BLANK_CODE   = DEFAULT_BLANK_CODE
) (
    input logic              clk,
    input logic              rst,
    display_scanner_if.slave bus
);

    localparam int MAX_LEN = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;
    localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic HAS_GUARD = (GUARD_CYCLES > 0);

    scan_state_t r_state;
    logic [1:0]  r_idx;
    frame_t      r_shadow;
    frame_t      r_pending;
    logic        r_pendValid;
    logic [3:0]  r_anodeN;
    logic [3:0]  r_digitCode;
    logic        r_dp;
    logic        r_frameDone;

    logic             w_tc;
    logic [CNT_W-1:0] w_timerLoadValue;
    logic             w_slotEnd;
    logic             w_boundary;
    logic             w_nextIsDrive;
    logic [1:0]       w_idxNext;
    frame_t           w_input;
    frame_t           w_shadowNext;
    logic [3:0]       w_nibbleNext;
    logic             w_blankNext;

    scan_timer #(.WIDTH(CNT_W)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_tc),
        .i_loadValue (w_timerLoadValue),
        .o_tc        (w_tc)
    );

    assign w_input          = {bus.value, bus.dp_mask, bus.lz_blank};
    assign w_slotEnd        = (r_state == S_DRIVE) && w_tc;
    assign w_boundary       = w_slotEnd && (r_idx == 2'd3);
    assign w_idxNext        = w_slotEnd ? r_idx + 2'd1 : r_idx;
    assign w_timerLoadValue = (r_state == S_DRIVE && HAS_GUARD) ? GUARD_LOAD : DRIVE_LOAD;
    assign w_nextIsDrive    = (r_state == S_DRIVE) ? !(w_tc && HAS_GUARD) : w_tc;

    // A load landing on the last cycle of a frame bypasses pending straight into the shadow.
    always_comb begin
        w_shadowNext = r_shadow;
        if (w_boundary) begin
            if (bus.load) begin
                w_shadowNext = w_input;
            end else if (r_pendValid) begin
                w_shadowNext = r_pending;
            end
        end
    end

    assign w_nibbleNext = w_shadowNext.value[{w_idxNext, 2'b00} +: 4];
    assign w_blankNext  = w_shadowNext.lzBlank && isLeadingZero(w_shadowNext.value, w_idxNext);

    // Outputs are computed from next-cycle state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_GUARD;
            r_idx       <= 2'd0;
            r_shadow    <= '0;
            r_pending   <= '0;
            r_pendValid <= 1'b0;
            r_anodeN    <= 4'b1111;
            r_digitCode <= BLANK_CODE;
            r_dp        <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            case (r_state)
                S_GUARD: begin
                    if (w_tc) begin
                        r_state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (w_tc) begin
                        r_idx <= r_idx + 2'd1;
                        if (HAS_GUARD) begin
                            r_state <= S_GUARD;
                        end
                    end
                end
                default: r_state <= S_GUARD;
            endcase

            r_shadow <= w_shadowNext;
            if (w_boundary) begin
                r_pendValid <= 1'b0;
            end else if (bus.load) begin
                r_pending   <= w_input;
                r_pendValid <= 1'b1;
            end

            r_frameDone <= w_boundary;
            if (w_nextIsDrive) begin
                r_anodeN    <= ~(4'b0001 << w_idxNext);
                r_digitCode <= w_blankNext ? BLANK_CODE : w_nibbleNext;
                r_dp        <= w_shadowNext.dpMask[w_idxNext];
            end else begin
                r_anodeN    <= 4'b1111;
                r_digitCode <= BLANK_CODE;
                r_dp        <= 1'b0;
            end
        end
    end

    assign bus.anode_n    = r_anodeN;
    assign bus.digit_code = r_digitCode;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frameDone;
    assign bus.busy       = r_pendValid;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (REFRESH_DIV=4, GUARD_CYCLES=1): every cycle is
// compared against a frame/slot model derived from cycle position since reset.
module tb_display_scanner;

    localparam int SLOT  = 5;
    localparam int FRAME = 20;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    int   cycleN;

    logic [15:0] shownVal;
    logic [3:0]  shownDp;
    logic        shownLz;
    logic [15:0] pendVal;
    logic [3:0]  pendDp;
    logic        pendLz;
    int          pendFrame;
    logic        pendValid;

    display_scanner_if bus ();

    display_scanner #(
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1),
        .BLANK_CODE   (4'd10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cycleN, observed, expected);
        end
    endtask

    // Model: cycle 0 is the dark slot right after reset; each 5-cycle slot is one guard
    // cycle then four lit cycles; a load in cycle n is shown from frame n/20+1 onward.
    task automatic checkOutput();
        int pos;
        int slot;
        int off;
        logic [15:0] upper;
        logic [3:0]  expAnode;
        logic [3:0]  expCode;
        logic        expDp;
        if (pendValid && pendFrame <= cycleN / FRAME) begin
            shownVal  = pendVal;
            shownDp   = pendDp;
            shownLz   = pendLz;
            pendValid = 1'b0;
        end
        pos  = cycleN % FRAME;
        slot = pos / SLOT;
        off  = pos % SLOT;
        upper = shownVal >> (4 * slot);
        if (off == 0) begin
            expAnode = 4'b1111;
            expCode  = 4'd10;
            expDp    = 1'b0;
        end else begin
            expAnode = 4'b1111;
            expAnode[slot] = 1'b0;
            expCode  = (shownLz && slot >= 1 && upper == 16'd0) ? 4'd10 : upper[3:0];
            expDp    = shownDp[slot];
        end
        checkOne("anode_n", 16'(bus.anode_n), 16'(expAnode));
        checkOne("digit_code", 16'(bus.digit_code), 16'(expCode));
        checkOne("dp", 16'(bus.dp), 16'(expDp));
        checkOne("frame_done", 16'(bus.frame_done), 16'(pos == 0 && cycleN > 0));
        checkOne("busy", 16'(bus.busy), 16'(pendValid));
    endtask

    task automatic resetModel();
        cycleN    = 0;
        shownVal  = 16'h0000;
        shownDp   = 4'b0000;
        shownLz   = 1'b0;
        pendValid = 1'b0;
        pendVal   = 16'h0000;
        pendDp    = 4'b0000;
        pendLz    = 1'b0;
        pendFrame = 0;
    endtask

    task automatic applyStimulus(input logic doLoad, input logic [15:0] v, input logic [3:0] d, input logic lz);
        bus.load     = doLoad;
        bus.value    = v;
        bus.dp_mask  = d;
        bus.lz_blank = lz;
        if (doLoad) begin
            pendVal   = v;
            pendDp    = d;
            pendLz    = lz;
            pendFrame = cycleN / FRAME + 1;
            pendValid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        cycleN++;
        checkOutput();
    endtask

    task automatic idle(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    task automatic idleUntil(input int pos);
        for (int i = 0; i < FRAME && (cycleN % FRAME) != pos; i++) begin
            applyStimulus(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_mask  = 4'b0000;
        bus.lz_blank = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput();

        $display("[TB] free-running scan of the reset value");
        idle(40);

        $display("[TB] mid-frame load of 1234 with dp on digit 2");
        idleUntil(7);
        applyStimulus(1'b1, 16'h1234, 4'b0100, 1'b0);
        idle(30);

        $display("[TB] leading-zero blanking");
        idleUntil(3);
        applyStimulus(1'b1, 16'h0050, 4'b0000, 1'b1);
        idle(25);
        idleUntil(3);
        applyStimulus(1'b1, 16'h0000, 4'b1000, 1'b1);
        idle(25);

        $display("[TB] last load wins, boundary-cycle bypass");
        idleUntil(2);
        applyStimulus(1'b1, 16'h1111, 4'b0001, 1'b0);
        idle(3);
        applyStimulus(1'b1, 16'h2222, 4'b0010, 1'b0);
        idle(25);
        idleUntil(19);
        applyStimulus(1'b1, 16'h5A0F, 4'b1001, 1'b1);
        idle(22);

        $display("[TB] randomized loads");
        for (int i = 0; i < 300; i++) begin
            logic [15:0] v;
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            applyStimulus(($urandom_range(0, 7) == 0), v, 4'($urandom), 1'($urandom));
        end

        $display("[TB] reset during the digit-2 slot");
        idleUntil(12);
        applyStimulus(1'b1, 16'hABCD, 4'b1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        resetModel();
        checkOutput();
        rst = 1'b0;
        idle(45);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
